csa_resolver: RTL and testbench

Sequential carry-save accumulator with a multi-cycle resolver. It accepts a stream of unsigned W-bit operands over a valid/ready handshake and folds each one into a redundant (sum, carry) pair using one 3:2 compression per accepted beat. On the last beat it converts the redundant pair to binary, CHUNK bits per cycle, and presents the AW-bit total on an output handshake. It consumes the carry-save (s, c) form that our CSA/FA datapath produces and turns it back into a plain binary result.

---
 rtl/csa_resolver.sv | 133 +++++++++++++
 tb/tb_csa_resolver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
// csa_resolver: carry-save operand accumulator with a chunked binary resolver.
// Optional overflow output enabled by defining CSA_RESOLVER_OVF_EN.
`timescale 1ns/1ps
module csa_resolver #(
  parameter int W     = 5,
  parameter int AW    = 8,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [W-1:0]  a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] y
`ifdef CSA_RESOLVER_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam int NCH = AW / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   s_q, s_d;
  logic [AW-1:0]   c_q, c_d;
  logic [AW-1:0]   y_q, y_d;
  logic [KW-1:0]   k_q, k_d;
  logic            rc_q, rc_d;
  logic [AW-1:0]   ae;
  logic [AW-1:0]   maj;
  logic [CHUNK:0]  csum;
  logic            accept;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    y_d     = y_q;
    k_d     = k_q;
    rc_d    = rc_q;
    ae      = '0;
    ae[W-1:0] = a;
    maj     = (s_q & c_q) | (s_q & ae) | (c_q & ae);
    csum    = {1'b0, s_q[k_q*CHUNK +: CHUNK]}
            + {1'b0, c_q[k_q*CHUNK +: CHUNK]}
            + (CHUNK+1)'(rc_q);
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          s_d = s_q ^ c_q ^ ae;
          // top majority bit falls off here (weight 2^AW)
          c_d = maj << 1;
          if (in_last) begin
            state_d = RESOLVE;
            k_d     = '0;
            rc_d    = 1'b0;
          end
        end
      end
      RESOLVE: begin
        y_d[k_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        rc_d = csum[CHUNK];
        k_d  = k_q + 1'b1;
        if (k_q == KLAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          k_d     = '0;
          rc_d    = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      rc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      y_q     <= y_d;
      k_q     <= k_d;
      rc_q    <= rc_d;
    end
  end

`ifdef CSA_RESOLVER_OVF_EN
  logic drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (accept) drop_d = drop_q | maj[AW-1];
    if (out_valid && out_ready) drop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= drop_d;
  end

  assign ovf = drop_q | rc_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed table-driven checks of csa_resolver.
// Covers latency, stall in DONE, idle gaps, wrap and reset abort.
`timescale 1ns/1ps
module tb_csa_resolver;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [4:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
`ifdef CSA_RESOLVER_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  csa_resolver #(.W(5), .AW(8), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef CSA_RESOLVER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [4:0] ops [9];
    bit         gaps;
    int         hold;
    logic [7:0] ey;
    bit         eovf;
  } vec_t;

  vec_t tv [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts and ends on a negedge.
  task automatic run_group(input vec_t v);
    int lat;
    bit done;
    for (int i = 0; i < v.n; i++) begin
      if (v.gaps && i > 0) begin
        in_valid = 1'b0;
        a = 5'd17;
        in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
      end
      in_valid = 1'b1;
      a = v.ops[i];
      in_last = (i == v.n - 1);
      check("in_ready_accum", int'(in_ready), 1);
      check("out_valid_accum", int'(out_valid), 0);
      @(posedge clk);
      if (i != v.n - 1) @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    lat = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
      else begin
        check("in_ready_resolve", int'(in_ready), 0);
        @(posedge clk);
        lat++;
      end
    end
    check("latency", lat, 2);
    check("y", int'(y), int'(v.ey));
`ifdef CSA_RESOLVER_OVF_EN
    check("ovf", int'(ovf), int'(v.eovf));
`endif
    for (int h = 0; h < v.hold; h++) begin
      in_valid = h[0];
      a = 5'd31;
      in_last = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_y", int'(y), int'(v.ey));
      check("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    check("done_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("ack_in_ready", int'(in_ready), 1);
    check("ack_out_valid", int'(out_valid), 0);
    check("ack_y_kept", int'(y), int'(v.ey));
`ifdef CSA_RESOLVER_OVF_EN
    check("ack_ovf_clear", int'(ovf), 0);
`endif
  endtask

  initial begin
    vec_t v4;
    for (int i = 0; i < 6; i++) begin
      tv[i].n = 0;
      tv[i].gaps = 1'b0;
      tv[i].hold = 0;
      tv[i].eovf = 1'b0;
      for (int j = 0; j < 9; j++) tv[i].ops[j] = '0;
    end
    tv[0].n = 3;
    tv[0].ops[0] = 5'd3; tv[0].ops[1] = 5'd5; tv[0].ops[2] = 5'd7;
    tv[0].ey = 8'd15;
    tv[1].n = 1;
    tv[1].ops[0] = 5'd31;
    tv[1].ey = 8'd31;
    tv[2].n = 9;
    for (int j = 0; j < 9; j++) tv[2].ops[j] = 5'd31;
    tv[2].ey = 8'd23;
    tv[2].eovf = 1'b1;
    tv[3].n = 2;
    tv[3].ops[0] = 5'd6; tv[3].ops[1] = 5'd9;
    tv[3].hold = 5;
    tv[3].ey = 8'd15;
    tv[4].n = 2;
    tv[4].ops[0] = 5'd1; tv[4].ops[1] = 5'd2;
    tv[4].ey = 8'd3;
    tv[5].n = 3;
    tv[5].ops[0] = 5'd10; tv[5].ops[1] = 5'd20; tv[5].ops[2] = 5'd1;
    tv[5].gaps = 1'b1;
    tv[5].ey = 8'd31;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    a = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_y", int'(y), 0);
`ifdef CSA_RESOLVER_OVF_EN
    check("rst_ovf", int'(ovf), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_group(tv[i]);

    // reset abort while resolving
    in_valid = 1'b1;
    a = 5'd25;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    check("pre_abort_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_y", int'(y), 0);
    check("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v4 = tv[1];
    v4.ops[0] = 5'd4;
    v4.ey = 8'd4;
    run_group(v4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
